// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter definitions: bus widths, FSM state encoding and
// one-hot grant encodings.
package wb_pkg;

   localparam int ADR_W = 32;
   localparam int DAT_W = 32;
   localparam int SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } arb_state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_timeout.sv
// Watchdog for the granted master: counts un-acked strobe cycles and raises a
// one-cycle error pulse when the count reaches TIMEOUT_CYCLES.
module wb_arb_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic active_i,
   input  logic stb_i,
   input  logic ack_i,
   output logic err_o
);

   localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      err_o = active_i && (cnt_q == LIMIT);
      cnt_d = cnt_q;
      // Clearing on the error cycle lets a stalled master see repeated pulses.
      if (!active_i || ack_i || err_o) begin
         cnt_d = '0;
      end else if (stb_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter (round-robin, cycle-granular ownership).
// Define WB_ARB_TIMEOUT_EN to build the strobe watchdog and error termination.
module wb_master_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,

  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,

  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,

  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic             s_ack_i,
  input  logic [DAT_W-1:0] s_dat_i,

  output logic [1:0]       grant_o
);

  arb_state_e state_q, state_d;
  logic       last_m1_q, last_m1_d;
  logic       m0_req, m1_req;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || last_m1_q)) begin
          state_d   = GNT0;
          last_m1_d = 1'b0;
        end else if (m1_req) begin
          state_d   = GNT1;
          last_m1_d = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_d = IDLE;
      GNT1:    if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
    end
  end

  always_comb begin
    grant_o  = GRANT_NONE;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    case (state_q)
      GNT0: begin
        grant_o  = GRANT_M0;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
      GNT1: begin
        grant_o  = GRANT_M1;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic bus_err;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .active_i (state_q != IDLE),
    .stb_i    (s_stb_o),
    .ack_i    (s_ack_i),
    .err_o    (bus_err)
  );

  assign m0_err_o = bus_err && (state_q == GNT0);
  assign m1_err_o = bus_err && (state_q == GNT1);
`else
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of cycles an un-acked strobe is tolerated before error termination (timeout build only).
REQ-002 Clocking and reset: one clock and one reset; reset is synchronous and active-high.
REQ-003 wb_clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  synchronous active-high reset.
REQ-005 m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master 0 (management core) bus cycle, strobe, write enable.
REQ-006 m0_sel_i  input  4; m0_adr_i, m0_dat_i  input  32 each  master 0 byte select, address, write data.
REQ-007 m0_ack_o, m0_err_o  output  1 each; m0_dat_o  output  32  master 0 termination and read data.
REQ-008 m1_* (cyc, stb, we, sel, adr, dat_i, ack, err, dat_o)  same directions and widths as m0_*  master 1 (DMA engine).
REQ-009 s_cyc_o, s_stb_o, s_we_o  output  1 each; s_sel_o  output  4; s_adr_o, s_dat_o  output  32  to the user-project address decoder.
REQ-010 s_ack_i  input  1; s_dat_i  input  32  decoder termination and read data.
REQ-011 grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1, 00 = idle).

Function
REQ-012 Request for master n SHALL be mN_cyc_i & mN_stb_i.
REQ-013 FSM states IDLE, GNT0, GNT1; IDLE -> GNTn on the clock edge after request n is sampled, so arbitration latency is one cycle.
REQ-014 Both requesting in IDLE: grant SHALL go to the master not granted last (round-robin pointer, 1 bit).
REQ-015 GNTn SHALL hold while mN_cyc_i = 1, covering multi-beat cycles; GNTn -> IDLE on the edge where mN_cyc_i = 0, giving one idle cycle between owners.
REQ-016 In GNTn, s_* outputs SHALL equal master n's inputs combinationally; in IDLE, s_cyc_o = s_stb_o = s_we_o = 0, s_sel_o, s_adr_o and s_dat_o = 0.
REQ-017 mN_ack_o = s_ack_i and mN_dat_o = s_dat_i only while grant_o[n] = 1; otherwise both SHALL be 0.
REQ-018 The non-granted master SHALL see no ack or err and SHALL stall; its request is never dropped.
REQ-019 The pointer SHALL update on entry to GNTn, recording n as last granted.
REQ-020 s_ack_i asserted in IDLE SHALL be ignored and SHALL not be forwarded.

Reset
REQ-021 On wb_rst_i, asserted at any time including mid-transfer: state = IDLE, grant_o = 00, pointer = "m1 last" so m0 wins the first tie, timeout counter = 0.
REQ-022 With reset asserted, all ack, err, s_cyc_o and s_stb_o outputs SHALL read 0 in the following cycle.

Configuration
REQ-023 Macro WB_ARB_TIMEOUT_EN defined: an 8+ bit counter, sized to TIMEOUT_CYCLES, increments each cycle s_stb_o = 1 and s_ack_i = 0, and clears on ack or when the state is not GNTn.
REQ-024 When the counter reaches TIMEOUT_CYCLES, mN_err_o of the granted master SHALL pulse for one cycle, the counter SHALL clear, and the grant SHALL stay until mN_cyc_i falls.
REQ-025 Macro undefined: no counter is built and m0_err_o = m1_err_o = 0 constantly.

Structure
REQ-026 The shared package (wb_pkg) SHALL hold the state enum (IDLE/GNT0/GNT1), the grant encodings, and the WB width constants (ADR_W = 32, DAT_W = 32, SEL_W = 4).
REQ-027 A single sub-module wb_arb_timeout (counter plus err pulse) SHALL be instantiated only under WB_ARB_TIMEOUT_EN; the rest is flat.

Verification
REQ-028 Single master: m0 writes adr 0x3800_0004, dat 0xDEAD_BEEF; decoder acks after 3 cycles -> grant_o = 01 one cycle after request, s_* mirrors m0, m0_ack_o pulses once, m1_ack_o stays 0.
REQ-029 Simultaneous request right after reset -> m0 granted first; after m0_cyc_i falls, one IDLE cycle, then m1 granted; the next tie goes to m0.
REQ-030 Burst hold: m1 holds cyc for 4 strobes to 0x3400_0000 while m0 requests -> m0 stalls with ack 0 until m1_cyc_i drops; no beat lost.
REQ-031 Reset mid-transfer: wb_rst_i asserted during GNT1 with stb high -> next cycle grant_o = 00, s_cyc_o = 0; after release, an m0/m1 tie resolves to m0.
REQ-032 Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): read to an unmapped address 0x3A00_0000 with no ack -> m0_err_o pulses exactly 8 cycles after the strobe; without the macro, err stays 0 and the bus hangs.
